// File: rtl/vdp_sync_decoder.sv
// Video sync decoder: recovers h/v counters, measures line/frame length and tracks horizontal lock.
// Optional recovered interlace field output enabled by defining VDP_SYNC_DECODER_FIELD_EN.
module vdp_sync_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        hsync,
   input  logic        p_video_vs_n,
   output logic [10:0] rx_h_cnt,
   output logic [9:0]  rx_v_cnt,
   output logic [10:0] line_length,
   output logic [9:0]  frame_lines,
   output logic        locked,
   output logic        pal_detect,
   output logic        sync_error,
   output logic        field
);

   localparam int unsigned HW        = 11;
   localparam int unsigned VW        = 10;
   localparam int unsigned H_MAX     = 2047;
   localparam int unsigned V_MAX     = 1023;
   localparam int unsigned PAL_LINES = 288;

   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} lock_state_t;

   lock_state_t   state_q, state_d;
   logic [HW-1:0] cand_q, cand_d;
   logic [1:0]    match_q, match_d;
   logic          miss_q, miss_d;
   logic          hs_q, vs_n_q;
   logic          lock_loss_c;

   // Edges only exist in enabled cycles; history is frozen otherwise
   logic          hs_edge_c, vs_edge_c, h_ovf_c;
   logic [HW-1:0] period_c;
   logic [VW-1:0] v_now_c;

   assign hs_edge_c = enable & hsync & ~hs_q;
   assign vs_edge_c = enable & ~p_video_vs_n & vs_n_q;
   assign h_ovf_c   = enable & ~hs_edge_c & (rx_h_cnt == HW'(H_MAX - 1));
   // Period saturates so a line that already overflowed cannot wrap to a short value
   assign period_c  = (rx_h_cnt == HW'(H_MAX)) ? rx_h_cnt : rx_h_cnt + HW'(1);
   // Line count including an hsync edge landing in this same cycle
   assign v_now_c   = (hs_edge_c && (rx_v_cnt != VW'(V_MAX))) ? rx_v_cnt + VW'(1) : rx_v_cnt;

   // Lock FSM next-state
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      match_d     = match_q;
      miss_d      = miss_q;
      lock_loss_c = 1'b0;
      if (h_ovf_c) begin
         state_d = SEARCH;
         match_d = 2'd0;
         miss_d  = 1'b0;
      end else if (hs_edge_c) begin
         case (state_q)
            SEARCH: begin
               state_d = CHECK;
               cand_d  = period_c;
               match_d = 2'd0;
            end
            CHECK: begin
               if (period_c == cand_q) begin
                  if (match_q == 2'd2) begin
                     state_d = LOCKED;
                     miss_d  = 1'b0;
                  end else begin
                     match_d = match_q + 2'd1;
                  end
               end else begin
                  cand_d  = period_c;
                  match_d = 2'd0;
               end
            end
            LOCKED: begin
               if (period_c == cand_q) begin
                  miss_d = 1'b0;
               end else if (!miss_q) begin
                  miss_d = 1'b1;
               end else begin
                  state_d     = SEARCH;
                  match_d     = 2'd0;
                  miss_d      = 1'b0;
                  lock_loss_c = 1'b1;
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q        <= 1'b0;
         vs_n_q      <= 1'b1;
         state_q     <= SEARCH;
         cand_q      <= '0;
         match_q     <= '0;
         miss_q      <= 1'b0;
         rx_h_cnt    <= '0;
         rx_v_cnt    <= '0;
         line_length <= '0;
         frame_lines <= '0;
         locked      <= 1'b0;
         pal_detect  <= 1'b0;
         sync_error  <= 1'b0;
      end else begin
         // Error is an event: it drops after one clock even if enable goes low
         sync_error <= h_ovf_c | lock_loss_c;
         if (enable) begin
            hs_q    <= hsync;
            vs_n_q  <= p_video_vs_n;
            state_q <= state_d;
            cand_q  <= cand_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            locked  <= (state_d == LOCKED);
            if (hs_edge_c) begin
               line_length <= period_c;
               rx_h_cnt    <= '0;
            end else if (rx_h_cnt != HW'(H_MAX)) begin
               rx_h_cnt <= rx_h_cnt + HW'(1);
            end
            if (vs_edge_c) begin
               frame_lines <= v_now_c;
               rx_v_cnt    <= '0;
               if (state_q == LOCKED) pal_detect <= (v_now_c >= VW'(PAL_LINES));
            end else begin
               rx_v_cnt <= v_now_c;
            end
         end
      end
   end

`ifdef VDP_SYNC_DECODER_FIELD_EN
   // Field = vsync arrived in the second half of the line
   always_ff @(posedge clk) begin
      if (reset) begin
         field <= 1'b0;
      end else if (vs_edge_c) begin
         field <= (rx_h_cnt >= (line_length >> 1));
      end
   end
`else
   assign field = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_sync_decoder.sv
// Scoreboard bench for vdp_sync_decoder: lock acquisition/loss, frame measurement, PAL detect,
// same-cycle h/v edges, enable freeze, h overflow and mid-run reset.
module tb_vdp_sync_decoder;

   logic        clk = 1'b0;
   logic        reset, enable, hsync, p_video_vs_n;
   logic [10:0] rx_h_cnt, line_length;
   logic [9:0]  rx_v_cnt, frame_lines;
   logic        locked, pal_detect, sync_error, field;

   vdp_sync_decoder dut (
      .clk(clk), .reset(reset), .enable(enable), .hsync(hsync), .p_video_vs_n(p_video_vs_n),
      .rx_h_cnt(rx_h_cnt), .rx_v_cnt(rx_v_cnt), .line_length(line_length),
      .frame_lines(frame_lines), .locked(locked), .pal_detect(pal_detect),
      .sync_error(sync_error), .field(field)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit    is_v;
      string tag;
      int    ll;
      int    lk;
      int    err;
      int    v;
      int    fl;
      int    fld;
   } exp_t;

   typedef struct { int len; int gap; int lk; int err; } lock_row_t;
   typedef struct { int n; int vs_j; int fl; } frame_row_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_err_pulses = 0;
   int   prev_len = 0;

   always @(negedge clk) if (sync_error) n_err_pulses++;

   task automatic check_val(input string tag, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
      end
   endtask

   task automatic cyc(input logic hs, input logic vsn, input logic en);
      @(negedge clk);
      hsync        = hs;
      p_video_vs_n = vsn;
      enable       = en;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (!e.is_v) begin
            check_val({e.tag, "_line_length"}, int'(line_length), e.ll);
            check_val({e.tag, "_rx_h_cnt"}, int'(rx_h_cnt), 0);
            check_val({e.tag, "_sync_error"}, int'(sync_error), e.err);
            if (e.lk >= 0) check_val({e.tag, "_locked"}, int'(locked), e.lk);
            if (e.v >= 0) check_val({e.tag, "_rx_v_cnt"}, int'(rx_v_cnt), e.v);
         end else begin
            check_val({e.tag, "_vs_rx_v_cnt"}, int'(rx_v_cnt), 0);
            check_val({e.tag, "_field"}, int'(field), e.fld);
            if (e.fl >= 0) begin
               check_val({e.tag, "_frame_lines"}, int'(frame_lines), e.fl);
               check_val({e.tag, "_pal_detect"}, int'(pal_detect), (e.fl >= 288) ? 1 : 0);
            end
         end
      end
   endtask

   // One line: hsync rises at j=0 (high 4 clocks); optional vsync low at j=vs_j for 3 clocks
   task automatic line(input string tag, input int len, input int gap, input int vs_j,
                       input int lk, input int err, input int v, input int fl);
      exp_t e;
      logic hs, vsn;
      int   h;
      for (int j = 0; j < len; j++) begin
         hs  = (j < 4);
         vsn = !((vs_j >= 0) && (j >= vs_j) && (j < vs_j + 3));
         if (j == 0) begin
            e = '{is_v: 1'b0, tag: tag, ll: prev_len, lk: lk, err: err, v: v, fl: -1, fld: 0};
            sb.push_back(e);
         end
         if ((vs_j >= 0) && (j == vs_j)) begin
            h = (vs_j == 0) ? prev_len - 1 : vs_j - 1;
`ifdef VDP_SYNC_DECODER_FIELD_EN
            e = '{is_v: 1'b1, tag: tag, ll: 0, lk: -1, err: 0, v: 0, fl: fl,
                  fld: (h >= prev_len / 2) ? 1 : 0};
`else
            e = '{is_v: 1'b1, tag: tag, ll: 0, lk: -1, err: 0, v: 0, fl: fl, fld: 0};
`endif
            sb.push_back(e);
         end
         cyc(hs, vsn, 1'b1);
         drain();
         if ((j == 10) && (gap > 0)) begin
            repeat (gap) cyc(1'b0, 1'b1, 1'b0);
            check_val({tag, "_enable_hold"}, int'(rx_h_cnt), 10);
         end
      end
      prev_len = len;
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_rst_h"}, int'(rx_h_cnt), 0);
      check_val({tag, "_rst_v"}, int'(rx_v_cnt), 0);
      check_val({tag, "_rst_ll"}, int'(line_length), 0);
      check_val({tag, "_rst_fl"}, int'(frame_lines), 0);
      check_val({tag, "_rst_locked"}, int'(locked), 0);
      check_val({tag, "_rst_pal"}, int'(pal_detect), 0);
      check_val({tag, "_rst_err"}, int'(sync_error), 0);
      check_val({tag, "_rst_field"}, int'(field), 0);
   endtask

   lock_row_t lock_tbl[12] = '{
      '{1368, 0, 0, 0}, '{1368, 0, 0, 0}, '{1368, 0, 0, 0}, '{1368, 0, 1, 0},
      '{1300, 0, 1, 0}, '{1368, 0, 1, 0}, '{1300, 0, 1, 0}, '{1300, 0, 1, 0},
      '{20,   0, 0, 1}, '{20,   0, 0, 0}, '{20,   7, 0, 0}, '{20,   0, 0, 0}
   };

   frame_row_t frame_tbl[7] = '{
      '{262, 1, -1}, '{262, 11, 262}, '{262, 1, 262}, '{313, 0, 262},
      '{313, 11, 313}, '{262, 1, 313}, '{1, 11, 262}
   };

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; enable = 1'b1; hsync = 1'b0; p_video_vs_n = 1'b1;
      cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      check_reset("por");
      reset = 1'b0;

      // First edge lands 1368 enabled clocks after reset release
      repeat (1367) cyc(1'b0, 1'b1, 1'b1);
      prev_len = 1368;
      foreach (lock_tbl[i]) begin
         line($sformatf("lock%0d", i + 1), lock_tbl[i].len, lock_tbl[i].gap, -1,
              lock_tbl[i].lk, lock_tbl[i].err, i + 1, -1);
         if (i == 7) check_val("no_err_single_miss", n_err_pulses, 0);
      end
      check_val("lock_loss_pulses", n_err_pulses, 1);

      foreach (frame_tbl[f]) begin
         for (int k = 0; k < frame_tbl[f].n; k++) begin
            line($sformatf("frm%0d", f + 1), 20, 0, (k == 0) ? frame_tbl[f].vs_j : -1,
                 1, 0, -1, (k == 0) ? frame_tbl[f].fl : -1);
         end
      end
      check_val("frames_no_err", n_err_pulses, 1);

      // Hsync stops: counter saturates with a single error pulse
      repeat (2100) cyc(1'b0, 1'b1, 1'b1);
      check_val("ovf_h_cnt", int'(rx_h_cnt), 2047);
      check_val("ovf_locked", int'(locked), 0);
      check_val("ovf_pulses", n_err_pulses, 2);
      check_val("ovf_err_low", int'(sync_error), 0);

      // Mid-run reset discards everything; first edge only enters CHECK
      reset = 1'b1;
      cyc(1'b0, 1'b1, 1'b1);
      check_reset("mid");
      reset = 1'b0;
      repeat (5) cyc(1'b0, 1'b1, 1'b1);
      prev_len = 6;
      line("post1", 20, 0, -1, 0, 0, 1, -1);
      line("post2", 20, 0, -1, 0, 0, 2, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vdp_sync_decoder.md
VDP_SYNC_DECODER -- requirements
Module: vdp_sync_decoder

Interface
REQ-001 SHALL have clk, input, 1: single system clock; all logic on rising edge.
REQ-002 SHALL have reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have enable, input, 1: clock enable; no state advances when 0.
REQ-004 SHALL have hsync, input, 1: active-high horizontal sync from the sync generator.
REQ-005 SHALL have p_video_vs_n, input, 1: active-low vertical sync.
REQ-006 SHALL have rx_h_cnt, output, 11: recovered clocks since last hsync edge.
REQ-007 SHALL have rx_v_cnt, output, 10: recovered hsync edges since last vsync edge.
REQ-008 SHALL have line_length, output, 11: last measured hsync period in enabled clocks.
REQ-009 SHALL have frame_lines, output, 10: last measured lines per frame.
REQ-010 SHALL have locked, output, 1: horizontal timing stable.
REQ-011 SHALL have pal_detect, output, 1: 1 = PAL-length frame.
REQ-012 SHALL have sync_error, output, 1: one-cycle pulse on lock loss or h overflow.
REQ-013 SHALL have field, output, 1: recovered interlace field.

Function
REQ-014 SHALL detect hsync rising edge and p_video_vs_n falling edge using registered previous values; edges counted only in enabled cycles.
REQ-015 On hsync edge: line_length <= rx_h_cnt+1; rx_h_cnt <= 0; rx_v_cnt <= rx_v_cnt+1, saturating at 1023.
REQ-016 Without hsync edge: rx_h_cnt increments; at 2047 it holds, pulses sync_error once, and forces lock FSM to SEARCH.
REQ-017 On vsync edge: frame_lines <= rx_v_cnt (hsync edge in the same cycle is counted first), then rx_v_cnt <= 0.
REQ-018 Lock FSM states SEARCH, CHECK, LOCKED; candidate period (11 bits), match counter (2 bits), miss counter (1 bit).
REQ-019 SEARCH: first hsync edge -> CHECK; candidate <= measured period; match <= 0.
REQ-020 CHECK: edge with period == candidate -> match+1; third consecutive match -> LOCKED; mismatch -> candidate <= new period, match <= 0, stay CHECK.
REQ-021 LOCKED: matching edge clears miss; mismatch with miss=0 sets miss; second consecutive mismatch -> SEARCH with one-cycle sync_error.
REQ-022 locked = 1 exactly while state is LOCKED.
REQ-023 pal_detect updated only on vsync edge while LOCKED: 1 if latched frame_lines >= 288, else 0; held otherwise.
REQ-024 Measured period excludes the cycle count during enable=0; enable=0 freezes all registers including edge history.

Reset
REQ-025 On reset: rx_h_cnt=0, rx_v_cnt=0, line_length=0, frame_lines=0, locked=0, pal_detect=0, sync_error=0, field=0, FSM=SEARCH, edge history = inactive (hsync 0, p_video_vs_n 1).
REQ-026 Reset mid-frame SHALL discard all measurements; first hsync edge after reset only starts SEARCH->CHECK.

Configuration
REQ-027 Macro VDP_SYNC_DECODER_FIELD_EN defined: on each vsync edge, field <= 1 if rx_h_cnt >= line_length/2 (shift right 1), else 0.
REQ-028 Macro undefined: field tied to 0; no field logic synthesized.

Verification
REQ-029 Reset then hsync every 1368 clocks -> locked=1 on the 4th hsync edge; line_length=1367+1=1368.
REQ-030 Locked at 1368, one line of 1300, then 1368 -> locked stays 1, no sync_error; two consecutive lines of 1300 -> locked=0 plus one sync_error pulse.
REQ-031 vsync every 262 lines -> frame_lines=262, pal_detect=0; switch to 313 lines -> pal_detect=1 after next vsync edge.
REQ-032 hsync stopped -> rx_h_cnt holds at 2047, single sync_error pulse, locked=0.
REQ-033 With VDP_SYNC_DECODER_FIELD_EN, vsync at h=0 then h=684 on alternate frames -> field 0,1 alternating; without macro field=0 always.
REQ-034 Hsync and vsync edge in same cycle after 261 counted lines -> frame_lines=262, rx_v_cnt=0.
